lc3b_fetch: RTL and testbench
=============================

Name: lc3b_fetch

Overview:
- Instruction-fetch stage of the LC-3b multicycle datapath, directly upstream of the instruction register.
- Owns the PC and runs the memory read handshake for each instruction word.
- Presents the fetched word with a one-cycle IR load strobe to the IR.
- Accepts PC redirects (branch/JMP/JSR/TRAP targets) from the control unit, including redirects that arrive mid-fetch.

Parameters:
- RESET_PC, 16'h0000, PC value after reset; bit 0 must be 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  control request to fetch the next instruction; sampled in IDLE only.
- pc_load  in  1  redirect strobe; PC takes pc_in.
- pc_in  in  16  redirect target.
- mem_read  out  1  memory read request.
- mem_address  out  16  word-aligned read address, equal to {pc[15:1],1'b0}.
- mem_rdata  in  16  memory read data; valid when mem_resp=1.
- mem_resp  in  1  memory response; completes the read.
- ir_load  out  1  one-cycle strobe to the IR load input.
- instr  out  16  captured instruction word; goes to the IR input.
- fetch_pc  out  16  address of the word currently in instr.
- pc  out  16  current PC register, used by the datapath for PC-relative math.
- busy  out  1  high in REQ and DONE.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, pc=RESET_PC, pending redirect cleared.
  - Outputs: instr=0, fetch_pc=0, mem_read=0, ir_load=0, busy=0.
  - Reset mid-REQ drops the request immediately; a late mem_resp after reset is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - mem_read=0.
  - pc_load=1 sets pc<=pc_in.
  - start=1 moves to REQ.
  - pc_load and start in the same cycle: pc<=pc_in and go to REQ. The fetch uses pc_in because mem_address is derived from the pc register.
- REQ:
  - mem_read=1; mem_address is held stable for the whole state.
  - On mem_resp=1: instr<=mem_rdata, fetch_pc<=mem_address, go to DONE.
  - Without mem_resp the block stays in REQ indefinitely; there is no timeout.
  - start is ignored.
  - pc_load during REQ does not disturb the outstanding read. pc_in is latched into a pending-redirect register; a later pc_load overwrites it.
- DONE (exactly one cycle):
  - ir_load=1, mem_read=0.
  - At the end of the cycle: if a redirect is pending or pc_load=1, pc takes the target and the pending flag clears. A live pc_load has priority over the pending value. Otherwise pc<=pc+2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
  - Next state is always IDLE.
- mem_resp outside REQ is ignored.
- Latency: start high at cycle 0 gives mem_read=1 from cycle 1. mem_resp at cycle k gives ir_load=1 and instr valid at cycle k+1, and IDLE at k+2.
  - Minimum round trip, with mem_resp in the first REQ cycle: 3 cycles from start to IDLE.
- instr and fetch_pc hold their values until the next successful fetch.
- pc_in bit 0 is stored as given; only mem_address forces bit 0 to 0.

Test Plan:
- Reset then start, with memory responding after 2 cycles with 16'h1263 at 0x0000:
  - mem_read=1, mem_address=0x0000 for exactly 2 cycles.
  - Next cycle: ir_load=1, instr=16'h1263, fetch_pc=0x0000.
  - Then pc=0x0002.
- Redirect in IDLE: pc_load=1 with pc_in=0x3000, same cycle as start:
  - mem_address=0x3000 in REQ.
  - After DONE, pc=0x3002.
- Redirect mid-fetch: pc_load=1 with pc_in=0x4000 on the second REQ cycle, then mem_resp:
  - mem_address stays 0x0002 throughout; instr equals the word at 0x0002.
  - After DONE, pc=0x4000 (not 0x0004).
- Wrap: pc_load with 0xFFFE, then start, with mem_resp:
  - mem_address=0xFFFE.
  - After DONE, pc=0x0000.
- Asynchronous reset asserted mid-REQ with pc at 0x0010:
  - mem_read and busy drop without waiting for a clock edge; pc=RESET_PC.
  - A mem_resp pulse arriving after reset is released causes no ir_load.
- Spurious mem_resp in IDLE, and start held high during REQ:
  - No ir_load, no pc change, and no second fetch queued.

Source files
------------

// File: rtl/lc3b_fetch.sv
// LC-3b instruction-fetch stage: owns the PC, runs the memory read handshake and
// strobes each fetched word into the IR. Redirects arriving mid-fetch are deferred.
module lc3b_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        ir_load,
  output logic [15:0] instr,
  output logic [15:0] fetch_pc,
  output logic [15:0] pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;

  // Control outputs decode straight from the state register so reset drops them at once.
  assign mem_read    = (state_q == REQ);
  assign ir_load     = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign mem_address = {pc_q[15:1], 1'b0};
  assign instr       = instr_q;
  assign fetch_pc    = fetch_pc_q;
  assign pc          = pc_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= 16'h0000;
      instr_q    <= 16'h0000;
      fetch_pc_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      instr_q    <= instr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next-state and next-PC logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    instr_d    = instr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_d = pc_in;
        end else begin
          pc_d = pc_q;
        end
        if (start) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // The outstanding read keeps its address; a redirect waits for DONE.
        if (pc_load) begin
          pend_d    = 1'b1;
          pend_pc_d = pc_in;
        end else begin
          pend_d    = pend_q;
        end
        if (mem_resp) begin
          instr_d    = mem_rdata;
          fetch_pc_d = mem_address;
          state_d    = DONE;
        end else begin
          state_d    = REQ;
        end
      end
      DONE: begin
        if (pc_load) begin
          pc_d = pc_in;
        end else if (pend_q) begin
          pc_d = pend_pc_q;
        end else begin
          pc_d = pc_q + 16'd2;
        end
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lc3b_fetch.sv
// Directed bench for lc3b_fetch: stimulus pushes expected fetches into a scoreboard,
// a negedge monitor pops one per ir_load and checks instr, fetch_pc and the next PC.
module tb_lc3b_fetch;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        pc_load;
  logic [15:0] pc_in;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        ir_load;
  logic [15:0] instr;
  logic [15:0] fetch_pc;
  logic [15:0] pc;
  logic        busy;

  typedef struct {
    logic [15:0] word;
    logic [15:0] addr;
    logic [15:0] npc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  lc3b_fetch #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .mem_read   (mem_read),
    .mem_address(mem_address),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .ir_load    (ir_load),
    .instr      (instr),
    .fetch_pc   (fetch_pc),
    .pc         (pc),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every IR load against the scoreboard, then the PC one cycle later.
  initial begin
    exp_t e;
    logic        pc_armed;
    logic [15:0] pc_exp;
    pc_armed = 1'b0;
    pc_exp   = 16'h0000;
    forever begin
      @(negedge clk);
      if (pc_armed) begin
        chk("pc_after_done", pc, pc_exp);
        pc_armed = 1'b0;
      end
      if (ir_load === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ir_load: got ir_load=1 instr=%h expected no load (t=%0t)", instr, $time);
        end else begin
          e = sb.pop_front();
          chk("instr", instr, e.word);
          chk("fetch_pc", fetch_pc, e.addr);
          pc_exp   = e.npc;
          pc_armed = 1'b1;
        end
      end
    end
  end

  // One fetch: start (caller may pre-set pc_load), lat REQ cycles, optional mid-fetch redirect.
  task automatic run_fetch(input logic [15:0] addr, input logic [15:0] word, input int lat,
                           input int redir_cyc, input logic [15:0] redir_tgt,
                           input logic hold_start, input logic [15:0] npc);
    exp_t e;
    e.word = word;
    e.addr = addr;
    e.npc  = npc;
    sb.push_back(e);
    start = 1'b1;
    step();
    start   = hold_start;
    pc_load = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      chk("req_mem_read", {15'd0, mem_read}, 16'h0001);
      chk("req_mem_address", mem_address, addr);
      chk("req_busy", {15'd0, busy}, 16'h0001);
      chk("req_no_ir_load", {15'd0, ir_load}, 16'h0000);
      if (c == redir_cyc) begin
        pc_load = 1'b1;
        pc_in   = redir_tgt;
      end else begin
        pc_load = 1'b0;
      end
      if (c == lat) begin
        mem_resp  = 1'b1;
        mem_rdata = word;
      end
      step();
    end
    pc_load  = 1'b0;
    mem_resp = 1'b0;
    start    = 1'b0;
    chk("done_mem_read", {15'd0, mem_read}, 16'h0000);
    chk("done_ir_load", {15'd0, ir_load}, 16'h0001);
    chk("done_busy", {15'd0, busy}, 16'h0001);
    step();
    chk("idle_busy", {15'd0, busy}, 16'h0000);
  endtask

  initial begin
    start     = 1'b0;
    pc_load   = 1'b0;
    pc_in     = 16'h0000;
    mem_rdata = 16'h0000;
    mem_resp  = 1'b0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_instr", instr, 16'h0000);
    chk("rst_fetch_pc", fetch_pc, 16'h0000);
    chk("rst_mem_read", {15'd0, mem_read}, 16'h0000);
    chk("rst_ir_load", {15'd0, ir_load}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_pc", pc, 16'h0000);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Basic fetch, response after 2 REQ cycles.
    run_fetch(16'h0000, 16'h1263, 2, 0, 16'h0000, 1'b0, 16'h0002);
    // Mid-fetch redirect on second REQ cycle.
    run_fetch(16'h0002, 16'h5020, 3, 2, 16'h4000, 1'b0, 16'h4000);
    // Redirect and start together in IDLE.
    pc_load = 1'b1;
    pc_in   = 16'h3000;
    run_fetch(16'h3000, 16'hE00A, 1, 0, 16'h0000, 1'b0, 16'h3002);
    // Wrap at top of memory.
    pc_load = 1'b1;
    pc_in   = 16'hFFFE;
    step();
    pc_load = 1'b0;
    chk("load_pc_fffe", pc, 16'hFFFE);
    run_fetch(16'hFFFE, 16'hF025, 1, 0, 16'h0000, 1'b0, 16'h0000);
    // Odd redirect target: bit 0 kept in pc, masked on the bus.
    pc_load = 1'b1;
    pc_in   = 16'h0011;
    step();
    pc_load = 1'b0;
    chk("load_pc_odd", pc, 16'h0011);
    run_fetch(16'h0010, 16'h1234, 1, 0, 16'h0000, 1'b0, 16'h0013);
    // Spurious response in IDLE.
    mem_resp  = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    mem_resp = 1'b0;
    chk("spur_pc", pc, 16'h0013);
    chk("spur_busy", {15'd0, busy}, 16'h0000);
    chk("spur_ir_load", {15'd0, ir_load}, 16'h0000);
    chk("spur_instr", instr, 16'h1234);
    step();
    // start held through REQ must not queue another fetch.
    run_fetch(16'h0012, 16'h2ABC, 2, 0, 16'h0000, 1'b1, 16'h0015);
    step();
    chk("hold_no_refetch_busy", {15'd0, busy}, 16'h0000);
    chk("hold_no_refetch_read", {15'd0, mem_read}, 16'h0000);
    step();
    // Asynchronous reset in the middle of a REQ at 0x0010.
    pc_load = 1'b1;
    pc_in   = 16'h0010;
    start   = 1'b1;
    step();
    pc_load = 1'b0;
    start   = 1'b0;
    chk("areq_mem_address", mem_address, 16'h0010);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_mem_read", {15'd0, mem_read}, 16'h0000);
    chk("arst_busy", {15'd0, busy}, 16'h0000);
    chk("arst_pc", pc, 16'h0000);
    step();
    reset_n   = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 16'hBEEF;
    step();
    mem_resp = 1'b0;
    chk("late_resp_ir_load", {15'd0, ir_load}, 16'h0000);
    chk("late_resp_busy", {15'd0, busy}, 16'h0000);
    step();
    chk("late_resp_ir_load2", {15'd0, ir_load}, 16'h0000);
    chk("late_resp_instr", instr, 16'h0000);
    step();
    chk("scoreboard_drained", sb.size()[15:0], 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
